aliens_rom_bus_responder: RTL and testbench

//  Responder end of the program-ROM chip-select decoded from the Aliens CPU bus.
//  On a decoded ROM read it holds the CPU with cpu_wait and fetches the byte from a
//  16-bit word memory (SDRAM/BRAM port) via a req/ack handshake. It then returns the byte.
//  Has a fetch timeout and an optional one-entry word cache.

---
 rtl/aliens_rom_bus_responder.sv | 211 +++++++++++++++++++++
 tb/tb_aliens_rom_bus_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aliens_rom_bus_responder.sv
// -----------------------------------------------------------------------------
// aliens_rom_bus_responder
//
// Purpose:
//   Responder for the program-ROM chip select decoded from the Aliens CPU bus.
//   A new ROM read stalls the CPU through o_cpu_wait. The responder then fetches
//   the containing 16-bit word from a word memory (SDRAM/BRAM port) using a level
//   request / pulse acknowledge handshake, and returns the addressed byte in
//   big-endian order. A fetch that is not acknowledged within TIMEOUT request
//   cycles is abandoned. The CPU then reads 8'hFF and a sticky error flag is set.
//
// Optional feature (macro ALIENS_ROM_CACHE_EN):
//   The macro adds a one-entry word cache that is filled on every completed
//   fetch. A read that hits the cached word is answered without a memory
//   request, after one wait cycle. Only reset clears the cache.
//
// Parameters:
//   ADDR_W   CPU byte-address width into the ROM region
//   TIMEOUT  maximum number of cycles o_mem_req may wait for i_mem_ack (1..255)
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_rom_cs_n     ROM chip select, active low
//   i_cpu_rd       CPU read strobe
//   i_cpu_addr     CPU byte address within the ROM region
//   o_cpu_dout     read data to the CPU, held until the next completed access
//   o_cpu_wait     CPU stall (combinational)
//   o_mem_req      word fetch request (level)
//   o_mem_addr     word address of the fetch
//   i_mem_ack      one-cycle pulse, i_mem_data is valid in that cycle
//   i_mem_data     fetched word
//   o_timeout_err  sticky fetch-timeout flag
// -----------------------------------------------------------------------------
module aliens_rom_bus_responder #(
  parameter int ADDR_W  = 17,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rom_cs_n,
  input  logic              i_cpu_rd,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  output logic [7:0]        o_cpu_dout,
  output logic              o_cpu_wait,
  output logic              o_mem_req,
  output logic [ADDR_W-2:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [15:0]       i_mem_data,
  output logic              o_timeout_err
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Big-endian byte select: an even byte address takes the high byte.
  function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic lo);
    return lo ? word[7:0] : word[15:8];
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_prev_access;
  logic [ADDR_W-1:0]   r_lat_addr;
  logic                r_mem_req;
  logic [ADDR_W-2:0]   r_mem_addr;
  logic [7:0]          r_cpu_dout;
  logic                r_timeout_err;
  logic [7:0]          r_cnt;

  logic                w_access;
  logic                w_start;
  logic                w_hit;
  logic [7:0]          w_hit_byte;
  logic                w_in_req;
  logic [7:0]          w_cnt_inc;
  logic                w_fetch_ok;
  logic                w_fetch_tmo;

  // A start needs a fresh access: either the CPU has just selected the ROM,
  // or it has moved to another address while it keeps the select asserted.
  // This prevents a held read from being fetched again after it completes.
  assign w_access    = ~i_rom_cs_n & i_cpu_rd;
  assign w_start     = w_access & (r_state == ST_IDLE) &
                       (~r_prev_access | (i_cpu_addr != r_lat_addr));
  assign w_in_req    = (r_state == ST_REQ);
  assign w_cnt_inc   = r_cnt + 8'd1;
  assign w_fetch_ok  = w_in_req & i_mem_ack;
  // An ack in the same cycle as the last allowed request cycle wins.
  assign w_fetch_tmo = w_in_req & ~i_mem_ack & (w_cnt_inc == TIMEOUT_C);

`ifdef ALIENS_ROM_CACHE_EN
  logic                r_cache_valid;
  logic [ADDR_W-2:0]   r_cache_waddr;
  logic [15:0]         r_cache_data;

  assign w_hit      = w_start & r_cache_valid &
                      (r_cache_waddr == i_cpu_addr[ADDR_W-1:1]);
  assign w_hit_byte = sel_byte(r_cache_data, i_cpu_addr[0]);

  // One-entry word cache, filled by every fetch that is acknowledged.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cache_valid <= 1'b0;
      r_cache_waddr <= '0;
      r_cache_data  <= 16'h0000;
    end else if (w_fetch_ok) begin
      r_cache_valid <= 1'b1;
      r_cache_waddr <= r_mem_addr;
      r_cache_data  <= i_mem_data;
    end else begin
      r_cache_valid <= r_cache_valid;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_byte = 8'hFF;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. A cache hit goes straight to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = w_hit ? ST_DONE : ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (w_fetch_ok | w_fetch_tmo) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: access tracking, request handshake, timeout counter, read data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev_access <= 1'b0;
      r_lat_addr    <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_cpu_dout    <= 8'hFF;
      r_timeout_err <= 1'b0;
      r_cnt         <= 8'd0;
    end else begin
      r_prev_access <= w_access;

      if (w_start) begin
        r_lat_addr <= i_cpu_addr;
      end

      // The request is never withdrawn early. If the CPU drops its select
      // while a fetch is pending, the fetch still runs to ack or timeout.
      if (w_start & ~w_hit) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= i_cpu_addr[ADDR_W-1:1];
      end else if (w_fetch_ok | w_fetch_tmo) begin
        r_mem_req  <= 1'b0;
      end

      if (w_start) begin
        r_cnt <= 8'd0;
      end else if (w_in_req) begin
        r_cnt <= w_cnt_inc;
      end

      // A fetch uses the latched byte lane, because the CPU may already have
      // moved away from the address.
      if (w_hit) begin
        r_cpu_dout <= w_hit_byte;
      end else if (w_fetch_ok) begin
        r_cpu_dout <= sel_byte(i_mem_data, r_lat_addr[0]);
      end else if (w_fetch_tmo) begin
        r_cpu_dout <= 8'hFF;
      end

      if (w_fetch_tmo) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_cpu_wait    = w_start | w_in_req;
  assign o_cpu_dout    = r_cpu_dout;
  assign o_mem_req     = r_mem_req;
  assign o_mem_addr    = r_mem_addr;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_aliens_rom_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_aliens_rom_bus_responder
//
// Self-checking bench for aliens_rom_bus_responder. It runs with TIMEOUT = 8.
// The bench checks the reset state first. A table of directed reads follows,
// then hand-written sequences for reset during a fetch and for CPU writes.
// A randomized phase comes last: each read is predicted by a transaction-level
// model of ROM reads, which includes the one-entry cache when
// ALIENS_ROM_CACHE_EN is defined.
// -----------------------------------------------------------------------------
module tb_aliens_rom_bus_responder;

  localparam int AW      = 17;
  localparam int TMO     = 8;
`ifdef ALIENS_ROM_CACHE_EN
  localparam bit CACHE   = 1'b1;
`else
  localparam bit CACHE   = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          rom_cs_n;
  logic          cpu_rd;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout;
  logic          cpu_wait;
  logic          mem_req;
  logic [AW-2:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_data;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   word;
    int            ack_at;      // request cycle in which ack is given, 0 = never
    int            abandon_at;  // read cycle in which the select is dropped, -1 = never
    logic [7:0]    exp_dout;
    int            exp_wait;
    int            exp_req;
    int            exp_rises;
    logic          exp_err;
  } vec_t;

  vec_t vecs[7];

  aliens_rom_bus_responder #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_rom_cs_n    (rom_cs_n),
    .i_cpu_rd      (cpu_rd),
    .i_cpu_addr    (cpu_addr),
    .o_cpu_dout    (cpu_dout),
    .o_cpu_wait    (cpu_wait),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_ack     (mem_ack),
    .i_mem_data    (mem_data),
    .o_timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] be_byte(input logic [15:0] w, input logic lo);
    logic [7:0] b;
    if (lo) b = w[7:0];
    else    b = w[15:8];
    return b;
  endfunction

  // Perform one CPU read and act as the memory side. Then idle for three
  // cycles with the select released and watch for any stray request.
  task automatic do_read(input logic [AW-1:0] addr, input logic [15:0] word,
                         input int ack_at, input int abandon_at,
                         output int wait_cyc, output int req_cyc,
                         output int rises, output logic [AW-2:0] maddr);
    bit prev;
    bit done;
    wait_cyc = 0; req_cyc = 0; rises = 0; maddr = '0; prev = 1'b0; done = 1'b0;
    rom_cs_n = 1'b0; cpu_rd = 1'b1; cpu_addr = addr;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (cyc == abandon_at) begin
        rom_cs_n = 1'b1; cpu_rd = 1'b0;
      end
      #1;
      if (cpu_wait) wait_cyc++;
      if (mem_req) begin
        req_cyc++;
        if (!prev) begin
          rises++;
          maddr = mem_addr;
        end
      end
      prev     = mem_req;
      mem_ack  = mem_req && (req_cyc == ack_at);
      mem_data = mem_ack ? word : 16'($urandom);
      if (!cpu_wait) done = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    check("read completes within cycle budget", 32'(done), 32'd1);
    mem_ack = 1'b0; rom_cs_n = 1'b1; cpu_rd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      if (mem_req && !prev) rises++;
      prev = mem_req;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int w, r, n;
    logic [AW-2:0] ma;
    do_read(v.addr, v.word, v.ack_at, v.abandon_at, w, r, n, ma);
    check($sformatf("%s dout", tag), 32'(cpu_dout), 32'(v.exp_dout));
    check($sformatf("%s wait cycles", tag), 32'(w), 32'(v.exp_wait));
    check($sformatf("%s req cycles", tag), 32'(r), 32'(v.exp_req));
    check($sformatf("%s req count", tag), 32'(n), 32'(v.exp_rises));
    check($sformatf("%s timeout_err", tag), 32'(timeout_err), 32'(v.exp_err));
    if (v.exp_req > 0) begin
      check($sformatf("%s mem_addr", tag), 32'(ma), 32'(v.addr[AW-1:1]));
    end
  endtask

  initial begin
    int            wh, rh;
    logic [7:0]    last_dout;
    vec_t          v;
    logic [15:0]   rmem[8];
    bit            cv;
    logic [AW-2:0] cw;
    logic [15:0]   cd;
    bit            merr;
    logic [AW-1:0] a;
    int            ack;

    // Directed table. With the cache, 0x00001 hits the word fetched for
    // 0x00000, and 0x00101 misses because a timed-out fetch fills nothing.
    vecs[0] = '{addr:17'h00000, word:16'hA55A, ack_at:3, abandon_at:-1,
                exp_dout:8'hA5, exp_wait:4, exp_req:3, exp_rises:1, exp_err:1'b0};
    vecs[1] = '{addr:17'h00001, word:16'h1234, ack_at:2, abandon_at:-1,
                exp_dout:(CACHE ? 8'h5A : 8'h34), exp_wait:(CACHE ? 1 : 3),
                exp_req:(CACHE ? 0 : 2), exp_rises:(CACHE ? 0 : 1), exp_err:1'b0};
    vecs[2] = '{addr:17'h1FFFE, word:16'hC3D4, ack_at:TMO, abandon_at:-1,
                exp_dout:8'hC3, exp_wait:TMO+1, exp_req:TMO, exp_rises:1, exp_err:1'b0};
    vecs[3] = '{addr:17'h00100, word:16'hBEEF, ack_at:0, abandon_at:-1,
                exp_dout:8'hFF, exp_wait:TMO+1, exp_req:TMO, exp_rises:1, exp_err:1'b1};
    vecs[4] = '{addr:17'h00101, word:16'hBEEF, ack_at:1, abandon_at:-1,
                exp_dout:8'hEF, exp_wait:2, exp_req:1, exp_rises:1, exp_err:1'b1};
    vecs[5] = '{addr:17'h00200, word:16'h5566, ack_at:5, abandon_at:1,
                exp_dout:8'h55, exp_wait:6, exp_req:5, exp_rises:1, exp_err:1'b1};
    vecs[6] = '{addr:17'h00200, word:16'h5566, ack_at:2, abandon_at:-1,
                exp_dout:8'h55, exp_wait:(CACHE ? 1 : 3),
                exp_req:(CACHE ? 0 : 2), exp_rises:(CACHE ? 0 : 1), exp_err:1'b1};

    reset = 1'b1; rom_cs_n = 1'b1; cpu_rd = 1'b0; cpu_addr = '0;
    mem_ack = 1'b0; mem_data = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset cpu_dout", 32'(cpu_dout), 32'hFF);
    check("reset cpu_wait", 32'(cpu_wait), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while a fetch is pending, then a stray ack after reset.
    rom_cs_n = 1'b0; cpu_rd = 1'b1; cpu_addr = 17'h00300;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("mid-fetch mem_req before reset", 32'(mem_req), 32'd1);
    reset = 1'b1; rom_cs_n = 1'b1; cpu_rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("mid-fetch reset mem_req", 32'(mem_req), 32'd0);
    check("mid-fetch reset cpu_wait", 32'(cpu_wait), 32'd0);
    check("mid-fetch reset timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0; mem_ack = 1'b1; mem_data = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("stray ack cpu_dout", 32'(cpu_dout), 32'hFF);
    check("stray ack mem_req", 32'(mem_req), 32'd0);

    // Reset also clears the cache, so address 0 must be fetched again.
    v = '{addr:17'h00000, word:16'h7788, ack_at:2, abandon_at:-1,
          exp_dout:8'h77, exp_wait:3, exp_req:2, exp_rises:1, exp_err:1'b0};
    run_vec(v, "post-reset read");
    last_dout = 8'h77;

    // CPU write cycles: no fetch, no stall, read data unchanged.
    wh = 0; rh = 0;
    rom_cs_n = 1'b0; cpu_rd = 1'b0; cpu_addr = 17'h01000;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (cpu_wait) wh++;
      if (mem_req)  rh++;
      @(posedge clk);
      @(negedge clk);
    end
    rom_cs_n = 1'b1;
    #1;
    check("write cpu_wait cycles", 32'(wh), 32'd0);
    check("write mem_req cycles", 32'(rh), 32'd0);
    check("write cpu_dout", 32'(cpu_dout), 32'(last_dout));

    // Random reads against a transaction-level model of the ROM.
    for (int i = 0; i < 8; i++) rmem[i] = 16'($urandom);
    cv = 1'b0; cw = '0; cd = 16'h0000; merr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      a   = 17'($urandom_range(0, 15));
      ack = $urandom_range(1, TMO + 2);
      v.addr = a; v.word = rmem[a[3:1]]; v.ack_at = ack; v.abandon_at = -1;
      if (CACHE && cv && (cw == a[AW-1:1])) begin
        v.exp_dout = be_byte(cd, a[0]); v.exp_wait = 1; v.exp_req = 0; v.exp_rises = 0;
      end else if (ack <= TMO) begin
        v.exp_dout = be_byte(v.word, a[0]); v.exp_wait = ack + 1;
        v.exp_req = ack; v.exp_rises = 1;
        cv = 1'b1; cw = a[AW-1:1]; cd = v.word;
      end else begin
        v.exp_dout = 8'hFF; v.exp_wait = TMO + 1; v.exp_req = TMO; v.exp_rises = 1;
        merr = 1'b1;
      end
      v.exp_err = merr;
      run_vec(v, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
